// File: rtl/icache.sv
// Direct-mapped, one-instruction-per-line instruction cache with a single outstanding miss.
// Define ICACHE_STATS_EN to add the hit_cnt / miss_cnt counter outputs.
module icache #(
    parameter int ICACHE_LINES = 256,
    parameter int INDEX_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        fetch_ena,
    input  logic [31:0] fetch_pc,
    input  logic        flush,
    output logic        ic_ready,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic        fet_ena,
    output logic [31:0] instr_addr,
    input  logic        valid_from_mc,
    input  logic [31:0] data_from_mc
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int TAG_W = 30 - INDEX_W;

    typedef enum logic [1:0] {IDLE, MISS, DROP} state_t;
    state_t state, state_nxt;

    logic [ICACHE_LINES-1:0] line_vld;
    logic [TAG_W-1:0]        tag_mem  [ICACHE_LINES];
    logic [31:0]             data_mem [ICACHE_LINES];

    logic [INDEX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0]   req_tag, fill_tag;
    logic               hit;
    logic               do_hit, do_miss, do_fill, deliver;
    logic               unused_pc;

    assign req_idx   = fetch_pc[INDEX_W+1:2];
    assign req_tag   = fetch_pc[31:INDEX_W+2];
    // The registered miss address doubles as the fill index/tag.
    assign fill_idx  = instr_addr[INDEX_W+1:2];
    assign fill_tag  = instr_addr[31:INDEX_W+2];
    assign unused_pc = ^fetch_pc[1:0];

    assign hit      = line_vld[req_idx] && (tag_mem[req_idx] == req_tag);
    assign ic_ready = (state == IDLE) && !flush;

    always_ff @(posedge clk) begin
        if (rst)      state <= IDLE;
        else if (rdy) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ic_ready && fetch_ena && !hit) state_nxt = MISS;
            MISS: begin
                if (valid_from_mc) state_nxt = IDLE;
                else if (flush)    state_nxt = DROP;
            end
            DROP: if (valid_from_mc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        do_hit  = 1'b0;
        do_miss = 1'b0;
        do_fill = 1'b0;
        deliver = 1'b0;
        case (state)
            IDLE: if (ic_ready && fetch_ena) begin
                do_hit  = hit;
                do_miss = !hit;
            end
            MISS: if (valid_from_mc) begin
                do_fill = 1'b1;
                deliver = !flush;
            end
            DROP: do_fill = valid_from_mc;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_vld    <= '0;
            fet_ena     <= 1'b0;
            instr_addr  <= '0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
        end else if (rdy) begin
            instr_valid <= do_hit || deliver;
            if (do_hit)       instr_out <= data_mem[req_idx];
            else if (deliver) instr_out <= data_from_mc;
            if (do_miss) begin
                fet_ena    <= 1'b1;
                instr_addr <= {fetch_pc[31:2], 2'b00};
            end else if (do_fill) begin
                fet_ena    <= 1'b0;
            end
            if (do_fill) line_vld[fill_idx] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset so they can map onto RAM.
    always_ff @(posedge clk) begin
        if (!rst && rdy && do_fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= data_from_mc;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (rdy) begin
            if (do_hit)  hit_cnt  <= hit_cnt + 32'd1;
            if (do_miss) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache.sv
// Randomized bench for icache against a transaction-level cache/controller reference model.
module tb_icache;
    localparam int LINES = 256;
    localparam int IW    = 8;

    logic        clk = 1'b0;
    logic        rst, rdy, fetch_ena, flush, valid_from_mc;
    logic [31:0] fetch_pc, data_from_mc;
    logic        ic_ready, instr_valid, fet_ena;
    logic [31:0] instr_out, instr_addr;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    icache #(.ICACHE_LINES(LINES), .INDEX_W(IW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .fetch_ena(fetch_ena), .fetch_pc(fetch_pc),
        .flush(flush), .ic_ready(ic_ready), .instr_valid(instr_valid), .instr_out(instr_out),
        .fet_ena(fet_ena), .instr_addr(instr_addr), .valid_from_mc(valid_from_mc),
        .data_from_mc(data_from_mc)
`ifdef ICACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: cache as word-address per line, one pending miss.
    bit          m_lv   [LINES];
    logic [29:0] m_word [LINES];
    logic [31:0] m_dat  [LINES];
    bit          m_busy, m_want;
    logic [31:0] m_pend;
    bit          m_valid, m_fet;
    logic [31:0] m_out, m_addr;
    int unsigned m_hits, m_miss;
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] memw(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_lv[i] = 1'b0;
        m_busy = 0; m_want = 0; m_pend = '0;
        m_valid = 0; m_fet = 0; m_out = '0; m_addr = '0;
        m_hits = 0; m_miss = 0;
    endtask

    task automatic cyc(input bit r, input bit rd, input bit fe, input logic [31:0] pc,
                       input bit fl, input bit vm, input logic [31:0] dm);
        int idx;
        rst = r; rdy = rd; fetch_ena = fe; fetch_pc = pc; flush = fl;
        valid_from_mc = vm; data_from_mc = dm;
        #1;
        chk("ic_ready", {31'b0, ic_ready}, {31'b0, !m_busy && !fl});
        if (r) begin
            model_reset();
        end else if (rd) begin
            m_valid = 0;
            if (!m_busy) begin
                if (fe && !fl) begin
                    idx = int'(pc[IW+1:2]);
                    if (m_lv[idx] && m_word[idx] == pc[31:2]) begin
                        m_valid = 1; m_out = m_dat[idx]; m_hits++;
                    end else begin
                        m_busy = 1; m_want = 1; m_pend = {pc[31:2], 2'b00};
                        m_fet = 1; m_addr = m_pend; m_miss++;
                    end
                end
            end else if (vm) begin
                idx = int'(m_pend[IW+1:2]);
                m_lv[idx] = 1; m_word[idx] = m_pend[31:2]; m_dat[idx] = dm;
                if (m_want && !fl) begin m_valid = 1; m_out = dm; end
                m_busy = 0; m_fet = 0;
            end else if (fl) begin
                m_want = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        chk("fet_ena", {31'b0, fet_ena}, {31'b0, m_fet});
        chk("instr_addr", instr_addr, m_addr);
        if (m_valid || r) chk("instr_out", instr_out, m_out);
`ifdef ICACHE_STATS_EN
        chk("hit_cnt", hit_cnt, m_hits);
        chk("miss_cnt", miss_cnt, m_miss);
`endif
    endtask

    task automatic idle();
        cyc(0, 1, 0, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic req(input logic [31:0] pc);
        cyc(0, 1, 1, pc, 0, 0, 32'h0);
    endtask

    task automatic ret(input logic [31:0] a);
        cyc(0, 1, 0, 32'h0, 0, 1, memw(a));
    endtask

    initial begin
        logic [31:0] pc;
        bit r, rd, fe, fl, vm;
        logic [31:0] dm;
        model_reset();
        mem[32'h10] = 32'h0000_0013;

        cyc(1, 1, 0, 32'h0, 0, 0, 32'h0);
        cyc(1, 0, 1, 32'h10, 0, 1, 32'hdead_beef);
        chk("rst_fet_ena", {31'b0, fet_ena}, 32'd0);

        // Cold miss, then hit.
        req(32'h10);
        chk("cold_addr", instr_addr, 32'h10);
        ret(32'h10);
        chk("cold_out", instr_out, 32'h13);
        req(32'h13);
        chk("hit_out", instr_out, 32'h13);
        chk("hit_fet", {31'b0, fet_ena}, 32'd0);

        // Conflict on the same index evicts, and the original line misses again.
        req(32'h410);
        chk("conflict_miss", {31'b0, fet_ena}, 32'd1);
        ret(32'h410);
        req(32'h10);
        chk("refetch_miss", {31'b0, fet_ena}, 32'd1);
        ret(32'h10);
`ifdef ICACHE_STATS_EN
        chk("stats_miss3", miss_cnt, 32'd3);
        chk("stats_hit1", hit_cnt, 32'd1);
`endif

        // Flush mid-miss: fetch stays up, no delivery, line still filled.
        req(32'h20);
        idle();
        cyc(0, 1, 1, 32'h10, 1, 0, 32'h0);
        repeat (4) idle();
        chk("drop_fet_held", {31'b0, fet_ena}, 32'd1);
        ret(32'h20);
        chk("drop_no_valid", {31'b0, instr_valid}, 32'd0);
        req(32'h20);
        chk("drop_fill_hit", {31'b0, instr_valid}, 32'd1);

        // Flush coincident with returned data.
        req(32'h24);
        cyc(0, 1, 0, 32'h0, 1, 1, memw(32'h24));

        // Pause mid-miss with a return pulse that must not be sampled.
        req(32'h30);
        repeat (3) cyc(0, 0, 1, 32'h10, 0, 1, 32'h1234_5678);
        chk("pause_fet", {31'b0, fet_ena}, 32'd1);
        ret(32'h30);
        chk("resume_out", instr_out, memw(32'h30));
        // Pause right after a hit holds the pulse.
        req(32'h10);
        repeat (2) cyc(0, 0, 0, 32'h0, 0, 0, 32'h0);

        // Spurious return in idle and reset during a miss.
        cyc(0, 1, 0, 32'h0, 0, 1, 32'hffff_ffff);
        req(32'h40);
        cyc(1, 1, 0, 32'h0, 0, 0, 32'h0);
        ret(32'h40);
        req(32'h10);

        for (int n = 0; n < 4000; n++) begin
            r  = ($urandom_range(0, 299) == 0);
            rd = ($urandom_range(0, 5) != 0);
            fe = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 11) == 0);
            pc = ($urandom_range(0, 3) << (IW + 2)) | ($urandom_range(0, 7) << 2)
               | $urandom_range(0, 3);
            if (m_busy) begin
                vm = ($urandom_range(0, 3) == 0);
                dm = memw(m_pend);
            end else begin
                vm = ($urandom_range(0, 9) == 0);
                dm = $urandom;
            end
            cyc(r, rd, fe, pc, fl, vm, dm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
